// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive-state type and default frame constants
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_OVERSAMPLING = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_sync_2ff.sv
// rtl/uart_sync_2ff.sv - two-flop synchroniser with a parameterised reset value
module uart_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - oversampled UART receiver with valid/ready output
// Optional parity stage compiled in with UART_RX_PARITY_EN.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int OVERSAMPLING = UART_OVERSAMPLING,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 overrun_error,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLING);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLING / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLING - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLING < 4 || (OVERSAMPLING % 2) != 0 ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
        $error("uart_rx_oversampled: illegal parameter combination");
    end

    logic                 w_rx_s;
    rx_state_t            r_state;
    logic [TW-1:0]        r_tick;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_fe;
    logic                 r_ovr;
    logic                 r_wait_high;

    uart_sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (w_rx_s)
    );

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic r_par;
    logic r_pe;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_tick      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_fe        <= 1'b0;
            r_ovr       <= 1'b0;
            r_wait_high <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par       <= 1'b0;
            r_pe        <= 1'b0;
`endif
        end else begin
            r_ovr <= 1'b0;
            if (r_valid && rx_ready)
                r_valid <= 1'b0;
            if (sample_tick) begin
                case (r_state)
                    IDLE: begin
                        // After a break the line must return high before a new start is accepted.
                        if (r_wait_high) begin
                            if (w_rx_s)
                                r_wait_high <= 1'b0;
                        end else if (!w_rx_s) begin
                            r_state <= START;
                            r_tick  <= '0;
                        end
                    end
                    START: begin
                        if (r_tick == TICK_MID) begin
                            r_tick <= '0;
                            r_bit  <= '0;
                            r_state <= w_rx_s ? IDLE : DATA;
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    DATA: begin
                        if (r_tick == TICK_LAST) begin
                            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                            r_tick  <= '0;
                            r_bit   <= r_bit + 1'b1;
                            if (r_bit == BIT_LAST)
`ifdef UART_RX_PARITY_EN
                                r_state <= PARITY;
`else
                                r_state <= STOP;
`endif
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (r_tick == TICK_LAST) begin
                            r_par   <= ((^r_shift) ^ w_rx_s) != PAR_ODD;
                            r_tick  <= '0;
                            r_state <= STOP;
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        // Return to IDLE at mid stop bit so an immediate next start edge is caught.
                        if (r_tick == TICK_LAST) begin
                            r_data      <= r_shift;
                            r_fe        <= ~w_rx_s;
                            r_valid     <= 1'b1;
                            r_ovr       <= r_valid && !rx_ready;
                            r_wait_high <= ~w_rx_s;
                            r_tick      <= '0;
                            r_state     <= IDLE;
`ifdef UART_RX_PARITY_EN
                            r_pe        <= r_par;
`endif
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign rx_data       = r_data;
    assign rx_valid      = r_valid;
    assign frame_error   = r_fe;
    assign overrun_error = r_ovr;
    assign busy          = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_error  = r_pe;
`else
    assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - self-checking bench for uart_rx_oversampled
module tb_uart_rx_oversampled;

    localparam int DB       = 8;
    localparam int OS       = 8;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = OS * TICK_DIV;

`ifdef UART_RX_PARITY_EN
    localparam bit PE_EN = 1'b1;
`else
    localparam bit PE_EN = 1'b0;
`endif

    logic          clock       = 1'b0;
    logic          reset       = 1'b1;
    logic          sample_tick = 1'b0;
    logic          rx          = 1'b1;
    logic          rx_ready    = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_error;
    logic          parity_error;
    logic          overrun_error;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int tick_ctr = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        tick_ctr    <= (tick_ctr == TICK_DIV - 1) ? 0 : tick_ctr + 1;
        sample_tick <= (tick_ctr == TICK_DIV - 1);
    end

    uart_rx_oversampled #(.DATA_BITS(DB), .OVERSAMPLING(OS), .PARITY_ODD(0)) dut (
        .clock         (clock),
        .reset         (reset),
        .sample_tick   (sample_tick),
        .rx            (rx),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .frame_error   (frame_error),
        .parity_error  (parity_error),
        .overrun_error (overrun_error),
        .busy          (busy)
    );

    typedef struct packed {
        logic [DB-1:0] data;
        logic          fe;
        logic          pe;
    } word_t;

    word_t acc_q[$];
    word_t exp_q[$];
    int valid_cycles = 0;
    int ovr_cycles   = 0;
    int busy_cycles  = 0;

    always @(negedge clock) begin
        if (!reset) begin
            if (rx_valid) valid_cycles++;
            if (rx_valid && rx_ready) acc_q.push_back({rx_data, frame_error, parity_error});
            if (overrun_error) ovr_cycles++;
            if (busy) busy_cycles++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) step();
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * BIT_CLKS) step();
    endtask

    // par_flip inverts the correct even parity bit when the parity stage is built in.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_b, input logic par_flip);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        if (PE_EN) drive_bit((^d) ^ par_flip);
        drive_bit(stop_b);
        rx = 1'b1;
    endtask

    task automatic expect_word(input string name, input logic [DB-1:0] d, input logic fe, input logic pe);
        word_t w;
        check({name, "_present"}, int'(acc_q.size() > 0), 1);
        if (acc_q.size() == 0) return;
        w = acc_q.pop_front();
        check({name, "_data"}, int'(w.data), int'(d));
        check({name, "_fe"}, int'(w.fe), int'(fe));
        check({name, "_pe"}, int'(w.pe), int'(pe));
    endtask

    typedef struct {
        logic [DB-1:0] data;
        logic          stop_b;
        logic [DB-1:0] exp_data;
        logic          exp_fe;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, b0, o0, n_rand;

        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
        vecs[2] = '{8'h3D, 1'b1, 8'h3D, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 8'hFF, 1'b1};
        vecs[5] = '{8'h80, 1'b1, 8'h80, 1'b0};

        reset = 1'b1;
        repeat (3) step();
        @(negedge clock);
        check("rst_valid", int'(rx_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_data", int'(rx_data), 0);
        check("rst_fe", int'(frame_error), 0);
        check("rst_pe", int'(parity_error), 0);
        check("rst_ovr", int'(overrun_error), 0);
        step();
        reset = 1'b0;
        idle_bits(1);

        rx_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            acc_q.delete();
            v0 = valid_cycles;
            o0 = ovr_cycles;
            send_frame(vecs[i].data, vecs[i].stop_b, 1'b0);
            idle_bits(2);
            check($sformatf("vec%0d_valid_cycles", i), valid_cycles - v0, 1);
            check($sformatf("vec%0d_ovr", i), ovr_cycles - o0, 0);
            check($sformatf("vec%0d_busy", i), int'(busy), 0);
            expect_word($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_fe, 1'b0);
        end

        acc_q.delete();
        v0 = valid_cycles;
        b0 = busy_cycles;
        rx = 1'b0;
        repeat (2 * TICK_DIV) step();
        rx = 1'b1;
        idle_bits(2);
        check("glitch_busy_seen", int'((busy_cycles - b0) > 0), 1);
        check("glitch_no_valid", valid_cycles - v0, 0);
        check("glitch_no_word", acc_q.size(), 0);
        check("glitch_busy_end", int'(busy), 0);

        acc_q.delete();
        rx_ready = 1'b0;
        o0 = ovr_cycles;
        send_frame(8'h11, 1'b1, 1'b0);
        idle_bits(1);
        send_frame(8'h22, 1'b1, 1'b0);
        idle_bits(1);
        check("ovr_pulse_cycles", ovr_cycles - o0, 1);
        check("ovr_valid_held", int'(rx_valid), 1);
        check("ovr_data", int'(rx_data), 8'h22);
        check("ovr_fe", int'(frame_error), 0);
        rx_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("ovr_valid_drop", int'(rx_valid), 0);
        check("ovr_one_word", acc_q.size(), 1);
        expect_word("ovr_word", 8'h22, 1'b0, 1'b0);
        step();

        acc_q.delete();
        v0 = valid_cycles;
        rx = 1'b0;
        repeat (12 * BIT_CLKS) step();
        idle_bits(2);
        check("break_words", acc_q.size(), 1);
        expect_word("break", 8'h00, 1'b1, 1'b0);
        check("break_busy_end", int'(busy), 0);

        rx_ready = 1'b0;
        send_frame(8'h44, 1'b1, 1'b0);
        idle_bits(1);
        check("pre_rst_valid", int'(rx_valid), 1);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        check("pre_rst_busy", int'(busy), 1);
        reset = 1'b1;
        step();
        @(negedge clock);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_valid", int'(rx_valid), 0);
        check("mid_rst_data", int'(rx_data), 0);
        step();
        reset = 1'b0;
        idle_bits(1);
        rx_ready = 1'b1;
        acc_q.delete();
        send_frame(8'h5A, 1'b1, 1'b0);
        idle_bits(2);
        expect_word("post_rst", 8'h5A, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
        acc_q.delete();
        send_frame(8'h07, 1'b1, 1'b1);
        idle_bits(2);
        expect_word("par_bad", 8'h07, 1'b0, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0);
        idle_bits(2);
        expect_word("par_good", 8'h07, 1'b0, 1'b0);
`endif

        acc_q.delete();
        exp_q.delete();
        n_rand = 16;
        for (int i = 0; i < n_rand; i++) begin
            logic [DB-1:0] d;
            logic          stop_b;
            d      = DB'($urandom_range(0, 255));
            stop_b = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(0, 7)) step();
            send_frame(d, stop_b, 1'b0);
            exp_q.push_back({d, ~stop_b, 1'b0});
            idle_bits($urandom_range(1, 3));
        end
        idle_bits(1);
        check("rand_count", acc_q.size(), exp_q.size());
        while (exp_q.size() > 0 && acc_q.size() > 0) begin
            word_t e, a;
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check($sformatf("rand_word_%0d", n_rand - exp_q.size() - 1), int'(a), int'(e));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
